// File: rtl/elevator_car_ctrl.sv
// Per-car motion/door sequencer: IDLE -> MOVE -> DOOR_OPEN -> DOOR_CLOSE -> IDLE.
// A trip takes 1 + N*FLOOR_TRAVEL_CYCLES + DOOR_OPEN_CYCLES + DOOR_CLOSE_CYCLES edges; estop freezes it.
module elevator_car_ctrl #(
  parameter int FLOOR_TRAVEL_CYCLES = 8,
  parameter int DOOR_OPEN_CYCLES    = 5,
  parameter int DOOR_CLOSE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] target,
  input  logic       move_enable,
  input  logic       door_hold,
  input  logic       estop,
  output logic [1:0] floor,
  output logic       busy,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       arrived
);

  localparam int MAX_AB  = (FLOOR_TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? FLOOR_TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
  localparam int MAX_CYC = (MAX_AB > DOOR_CLOSE_CYCLES) ? MAX_AB : DOOR_CLOSE_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_LAST   = TW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [TW-1:0] CLOSE_LAST  = TW'(DOOR_CLOSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN,
    S_DOOR_CLOSE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    floor_q, floor_d;
  logic [1:0]    target_q, target_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          arrived_q, arrived_d;
  logic [1:0]    step_floor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      floor_q   <= 2'd0;
      target_q  <= 2'd0;
      timer_q   <= '0;
      arrived_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      arrived_q <= arrived_d;
    end
  end

  // Floor the car reaches when the current travel segment completes.
  assign step_floor = (state_q == S_MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    target_d  = target_q;
    timer_d   = timer_q;
    arrived_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (move_enable) begin
          target_d = target;
          timer_d  = '0;
          if (target > floor_q) begin
            state_d = S_MOVE_UP;
          end else if (target < floor_q) begin
            state_d = S_MOVE_DOWN;
          end else begin
            state_d   = S_DOOR_OPEN;
            arrived_d = 1'b1;
          end
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (!estop) begin
          if (timer_q == TRAVEL_LAST) begin
            timer_d = '0;
            floor_d = step_floor;
            if (step_floor == target_q) begin
              state_d   = S_DOOR_OPEN;
              arrived_d = 1'b1;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_DOOR_OPEN: begin
        // estop outranks door_hold here: the timer simply holds.
        if (!estop) begin
          if (door_hold) begin
            timer_d = '0;
          end else if (timer_q == OPEN_LAST) begin
            state_d = S_DOOR_CLOSE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_DOOR_CLOSE: begin
        // A closing door always reopens on door_hold, even under estop.
        if (door_hold) begin
          state_d = S_DOOR_OPEN;
          timer_d = '0;
        end else if (!estop) begin
          if (timer_q == CLOSE_LAST) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign floor       = floor_q;
  assign busy        = (state_q != S_IDLE);
  assign moving_up   = (state_q == S_MOVE_UP) && !estop;
  assign moving_down = (state_q == S_MOVE_DOWN) && !estop;
  assign door_open   = (state_q == S_DOOR_OPEN);
  assign arrived     = arrived_q;

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
Per-car motion and door controller; one instance per elevator car. It accepts a target floor and a move_enable pulse from the dual-car scheduler, then sequences the car through travel, door open, door hold and door close. It reports the car's floor, busy flag and direction back to the scheduler. Floors are encoded 0=G, 1, 2, 3.

Parameters:
FLOOR_TRAVEL_CYCLES, 8, clock cycles to travel one floor (>=1)
DOOR_OPEN_CYCLES, 5, cycles the door stays open, absent door_hold (>=1)
DOOR_CLOSE_CYCLES, 2, cycles the door takes to close (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
target  input  2  requested floor; sampled only when move_enable=1 in IDLE
move_enable  input  1  start request from the scheduler
door_hold  input  1  door-open button or obstruction, level
estop  input  1  emergency stop, level; freezes all timers
floor  output  2  current car floor
busy  output  1  1 in every state except IDLE
moving_up  output  1  1 in MOVE_UP while estop=0
moving_down  output  1  1 in MOVE_DOWN while estop=0
door_open  output  1  1 in DOOR_OPEN
arrived  output  1  1-cycle pulse on the cycle DOOR_OPEN is entered

Behaviour:
- All outputs are decoded from state, floor and the arrived registers only. The one exception is the estop gating of moving_up/moving_down. No other input-to-output combinational path exists.
- Reset (async): state=IDLE, floor=0, target_q=0, timer=0, arrived=0. Therefore busy=0, moving_up=0, moving_down=0, door_open=0.
- Reset mid-operation returns the block to the reset state immediately. Travel in progress is abandoned and floor reads 0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_CLOSE. A single timer is used, sized for the largest parameter, and cleared on every state change.
- IDLE:
  - If move_enable=1 at an edge, target is latched into target_q.
  - Next state: MOVE_UP if target>floor; MOVE_DOWN if target<floor; DOOR_OPEN if target==floor, with arrived=1.
  - move_enable is ignored in every other state; no queueing.
- MOVE_UP / MOVE_DOWN:
  - Timer increments each cycle while estop=0.
  - At timer==FLOOR_TRAVEL_CYCLES-1, the next edge does floor±1 and timer=0.
  - If the new floor==target_q, the same edge moves to DOOR_OPEN and sets arrived=1.
  - Floor never wraps; target_q is constrained to 0..3, so no overrun is possible.
- DOOR_OPEN:
  - Timer increments while estop=0 and door_hold=0.
  - door_hold=1 forces timer=0, so the full DOOR_OPEN_CYCLES restart after release.
  - At timer==DOOR_OPEN_CYCLES-1 with door_hold=0, the next state is DOOR_CLOSE.
- DOOR_CLOSE:
  - Timer increments while estop=0.
  - door_hold=1 at any edge returns to DOOR_OPEN with timer=0; arrived is not re-pulsed.
  - At timer==DOOR_CLOSE_CYCLES-1 with door_hold=0, the next state is IDLE.
- estop=1: state, floor and timer hold in every state. move_enable in IDLE is still honoured; the first MOVE cycle then freezes.
- Latency: move_enable sampled at edge 0, N=|target-floor|.
  - DOOR_OPEN is entered at edge 1+N·FLOOR_TRAVEL_CYCLES.
  - IDLE (busy=0) is reached at edge 1+N·T+DOOR_OPEN_CYCLES+DOOR_CLOSE_CYCLES, assuming no hold or estop.
- Simultaneous door_hold and estop: estop wins and the timer holds. door_hold still forces a reopen from DOOR_CLOSE.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 and floor=0 immediately, without waiting for a clock edge.
- Travel G→3 with defaults: move_enable, target=3 at edge 0 -> moving_up from edge 1; floor=1,2,3 at edges 9,17,25; arrived=1 for the cycle after edge 25; door_open for edges 25–30; busy=0 from edge 32.
- Same floor: floor=2, target=2 at edge 0 -> DOOR_OPEN at edge 1 with arrived=1 and moving_* never set; busy=0 at edge 8.
- Door hold: door_hold high for 3 cycles starting at DOOR_OPEN timer=3 -> door_open extended to 5 cycles after release. door_hold for 1 cycle during DOOR_CLOSE -> door_open=1 again, with no arrived pulse.
- Busy ignore: move_enable with target=0 at edge 4 of a G→3 trip -> no effect; the car still arrives at floor 3 and target_q stays 3.
- Estop: estop high for 3 cycles during MOVE_DOWN 3→1 -> moving_down=0 during estop; floor=1 arrives 3 cycles late, at edge 20 instead of 17.
